mlp_feature_packer: RTL and testbench

Front/back-end sequencer for the combinational approximate-MLP classifier. It accepts input features serially, one 4-bit feature per beat over a valid/ready stream, and packs them into the classifier's 44-bit input bus. It holds that bus stable for a programmable settle window, then captures the 3-bit class index and returns it over a valid/ready result stream.

---
 rtl/mlp_feature_packer.sv | 99 +++++++++
 tb/tb_mlp_feature_packer.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mlp_feature_packer.sv
// Serial 4-bit feature packer and settle/capture sequencer for the combinational MLP classifier.
// Latency: the result is valid SETTLE_CYC cycles after the last beat. Backpressure: feat_ready is low outside LOAD, and the result holds until res_ready.
module mlp_feature_packer #(
  parameter int NUM_FEAT   = 11,
  parameter int FEAT_W     = 4,
  parameter int CLS_W      = 3,
  parameter int SETTLE_CYC = 2,
  parameter int CNT_W      = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       feat_valid,
  output logic                       feat_ready,
  input  logic [FEAT_W-1:0]          feat_data,
  input  logic                       feat_last,
  output logic [NUM_FEAT*FEAT_W-1:0] clf_inp,
  input  logic [CLS_W-1:0]           clf_out,
  output logic                       res_valid,
  input  logic                       res_ready,
  output logic [CLS_W-1:0]           res_class,
  output logic                       frame_err,
  output logic [CNT_W-1:0]           frame_cnt
);

  localparam int IDX_W = (NUM_FEAT > 1) ? $clog2(NUM_FEAT) : 1;
  localparam int SC_W  = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_FEAT - 1);
  localparam logic [SC_W-1:0]  SETTLE_END = SC_W'(SETTLE_CYC - 1);

  typedef enum logic [1:0] {LOAD, SETTLE, HOLD} state_t;

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic [SC_W-1:0]  settle_cnt;
  logic             beat;

  assign beat = feat_valid && feat_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= LOAD;
      idx        <= '0;
      settle_cnt <= '0;
      clf_inp    <= '0;
      res_class  <= '0;
      res_valid  <= 1'b0;
      feat_ready <= 1'b0;
      frame_err  <= 1'b0;
      frame_cnt  <= '0;
    end else begin
      frame_err <= 1'b0;
      case (state)
        LOAD: begin
          feat_ready <= 1'b1;
          if (beat) begin
            for (int k = 0; k < NUM_FEAT; k++) begin
              if (idx == IDX_W'(k)) clf_inp[k*FEAT_W +: FEAT_W] <= feat_data;
            end
            if (idx == LAST_IDX) begin
              idx <= '0;
              if (feat_last) begin
                state      <= SETTLE;
                settle_cnt <= '0;
                feat_ready <= 1'b0;
              end else begin
                // Long frame: the whole frame is discarded.
                frame_err <= 1'b1;
              end
            end else if (feat_last) begin
              // Short frame: restart at beat 0 without clearing stale nibbles.
              idx       <= '0;
              frame_err <= 1'b1;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        SETTLE: begin
          settle_cnt <= settle_cnt + 1'b1;
          if (settle_cnt == SETTLE_END) begin
            res_class <= clf_out;
            res_valid <= 1'b1;
            state     <= HOLD;
          end
        end
        HOLD: begin
          if (res_ready) begin
            frame_cnt  <= frame_cnt + 1'b1;
            res_valid  <= 1'b0;
            feat_ready <= 1'b1;
            state      <= LOAD;
          end
        end
        default: state <= LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_mlp_feature_packer.sv
// Randomized bench for mlp_feature_packer against a frame-level reference model.
module tb_mlp_feature_packer;
  localparam int NF = 11;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, feat_valid, feat_ready, feat_last, res_valid, res_ready, frame_err;
  logic [3:0]  feat_data;
  logic [43:0] clf_inp;
  logic [2:0]  clf_out, res_class;
  logic [15:0] frame_cnt;

  logic        rst1, feat_valid1, feat_ready1, feat_last1, res_valid1, res_ready1, frame_err1;
  logic [3:0]  feat_data1;
  logic [43:0] clf_inp1;
  logic [2:0]  clf_out1, res_class1;
  logic [3:0]  frame_cnt1;

  int checks = 0;
  int errors = 0;

  logic [3:0] mbus [NF];
  int         mpos;
  int         mcnt;

  // Stand-in classifier: inverted low bits of the feature sum.
  function automatic logic [2:0] cls_of(input logic [43:0] b);
    logic [7:0] s;
    s = '0;
    for (int k = 0; k < NF; k++) s = s + 8'(b[k*4 +: 4]);
    return s[2:0] ^ 3'b111;
  endfunction

  function automatic logic [43:0] model_bus();
    logic [43:0] p;
    for (int k = 0; k < NF; k++) p[k*4 +: 4] = mbus[k];
    return p;
  endfunction

  assign clf_out  = cls_of(clf_inp);
  assign clf_out1 = cls_of(clf_inp1);

  mlp_feature_packer dut (
    .clk(clk), .rst(rst), .feat_valid(feat_valid), .feat_ready(feat_ready),
    .feat_data(feat_data), .feat_last(feat_last), .clf_inp(clf_inp), .clf_out(clf_out),
    .res_valid(res_valid), .res_ready(res_ready), .res_class(res_class),
    .frame_err(frame_err), .frame_cnt(frame_cnt)
  );

  mlp_feature_packer #(.SETTLE_CYC(1), .CNT_W(4)) dut1 (
    .clk(clk), .rst(rst1), .feat_valid(feat_valid1), .feat_ready(feat_ready1),
    .feat_data(feat_data1), .feat_last(feat_last1), .clf_inp(clf_inp1), .clf_out(clf_out1),
    .res_valid(res_valid1), .res_ready(res_ready1), .res_class(res_class1),
    .frame_err(frame_err1), .frame_cnt(frame_cnt1)
  );

  task automatic model_reset();
    for (int k = 0; k < NF; k++) mbus[k] = 4'h0;
    mpos = 0;
    mcnt = 0;
  endtask

  task automatic idle(input int n);
    feat_valid = 1'b0;
    repeat (n) begin
      feat_data = 4'($urandom);
      feat_last = 1'($urandom);
      @(negedge clk);
    end
  endtask

  task automatic send_beat(input logic [3:0] d, input logic l);
    int n;
    logic exp_err;
    n = 0;
    feat_valid = 1'b1; feat_data = d; feat_last = l;
    while (feat_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 100) begin
      errors++;
      $display("FAIL beat_timeout feat_ready=%b required 1", feat_ready);
    end
    @(negedge clk);
    feat_valid = 1'b0; feat_data = 4'($urandom); feat_last = 1'($urandom);
    exp_err = 1'b0;
    mbus[mpos] = d;
    if (mpos == NF - 1) begin
      exp_err = !l;
      mpos = 0;
    end else if (l) begin
      exp_err = 1'b1;
      mpos = 0;
    end else begin
      mpos++;
    end
    checks++;
    if (frame_err !== exp_err) begin
      errors++;
      $display("FAIL frame_err got=%b want=%b", frame_err, exp_err);
    end
  endtask

  task automatic expect_result(input int lat, input int stall);
    logic [43:0] eb;
    logic [2:0]  ec;
    eb = model_bus();
    ec = cls_of(eb);
    for (int i = 0; i < lat; i++) begin
      checks++;
      if (res_valid !== 1'b0 || feat_ready !== 1'b0) begin
        errors++;
        $display("FAIL settle_early res_valid=%b feat_ready=%b want 0 0", res_valid, feat_ready);
      end
      @(negedge clk);
    end
    checks++;
    if (res_valid !== 1'b1 || clf_inp !== eb || res_class !== ec) begin
      errors++;
      $display("FAIL result res_valid=%b clf_inp=%h class=%0d want 1 %h %0d",
               res_valid, clf_inp, res_class, eb, ec);
    end
    res_ready = 1'b0;
    repeat (stall) begin
      feat_valid = 1'($urandom); feat_data = 4'($urandom);
      @(negedge clk);
      checks++;
      if ({res_valid, res_class, clf_inp, feat_ready} !== {1'b1, ec, eb, 1'b0}) begin
        errors++;
        $display("FAIL hold_stable res_valid=%b class=%0d clf_inp=%h feat_ready=%b",
                 res_valid, res_class, clf_inp, feat_ready);
      end
    end
    feat_valid = 1'b0;
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    mcnt++;
    checks++;
    if (res_valid !== 1'b0 || feat_ready !== 1'b1 || frame_cnt !== 16'(mcnt)) begin
      errors++;
      $display("FAIL handshake res_valid=%b feat_ready=%b frame_cnt=%0d want 0 1 %0d",
               res_valid, feat_ready, frame_cnt, mcnt);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({feat_ready, res_valid, frame_err, res_class, clf_inp, frame_cnt} !== '0) begin
      errors++;
      $display("FAIL reset_values rdy=%b vld=%b err=%b cls=%0d inp=%h cnt=%0d want all 0",
               feat_ready, res_valid, frame_err, res_class, clf_inp, frame_cnt);
    end
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    checks++;
    if (feat_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_after_reset got=%b want=1", feat_ready);
    end
  endtask

  task automatic test_basic(input int stall);
    for (int k = 1; k <= NF; k++) send_beat(4'(k), k == NF);
    expect_result(2, stall);
    checks++;
    if (clf_inp !== 44'hBA987654321 || res_class !== 3'd5) begin
      errors++;
      $display("FAIL basic_frame clf_inp=%h class=%0d want ba987654321 5", clf_inp, res_class);
    end
  endtask

  task automatic test_short_frame();
    for (int k = 1; k <= 4; k++) send_beat(4'(k), k == 4);
    idle(3);
    checks++;
    if (res_valid !== 1'b0 || frame_err !== 1'b0) begin
      errors++;
      $display("FAIL short_no_result res_valid=%b frame_err=%b want 0 0", res_valid, frame_err);
    end
    for (int k = 0; k < NF; k++) send_beat(4'hF, k == NF - 1);
    expect_result(2, 0);
    checks++;
    if (clf_inp !== 44'hFFFFFFFFFFF) begin
      errors++;
      $display("FAIL short_recover clf_inp=%h want fffffffffff", clf_inp);
    end
  endtask

  task automatic test_long_frame();
    for (int k = 0; k < NF; k++) send_beat(4'($urandom), 1'b0);
    idle(3);
    checks++;
    if (res_valid !== 1'b0) begin
      errors++;
      $display("FAIL long_no_result res_valid=%b want 0", res_valid);
    end
    for (int k = 0; k < NF; k++) send_beat(4'($urandom), k == NF - 1);
    expect_result(2, 1);
  endtask

  task automatic test_reset_mid();
    for (int w = 0; w < 2; w++) begin
      for (int k = 0; k < NF; k++) send_beat(4'($urandom), k == NF - 1);
      if (w == 1) begin
        repeat (2) @(negedge clk);
        checks++;
        if (res_valid !== 1'b1) begin
          errors++;
          $display("FAIL pre_reset_hold res_valid=%b want 1", res_valid);
        end
      end
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if (res_valid !== 1'b0 || clf_inp !== '0 || frame_cnt !== '0 || feat_ready !== 1'b0) begin
        errors++;
        $display("FAIL mid_reset res_valid=%b clf_inp=%h frame_cnt=%0d feat_ready=%b want 0 0 0 0",
                 res_valid, clf_inp, frame_cnt, feat_ready);
      end
      rst = 1'b0;
      model_reset();
      @(negedge clk);
      checks++;
      if (feat_ready !== 1'b1) begin
        errors++;
        $display("FAIL mid_reset_ready got=%b want=1", feat_ready);
      end
    end
  endtask

  task automatic test_random();
    int mode, len;
    for (int f = 0; f < 25; f++) begin
      mode = $urandom_range(0, 9);
      len = (mode == 0) ? $urandom_range(1, NF - 1) : NF;
      for (int k = 0; k < len; k++) begin
        idle($urandom_range(0, 2));
        send_beat(4'($urandom), (mode == 1) ? 1'b0 : (k == len - 1));
      end
      if (mode > 1) expect_result(2, $urandom_range(0, 5));
    end
  endtask

  task automatic test_settle1_wrap();
    logic [43:0] eb;
    int cnt1;
    rst1 = 1'b1;
    @(negedge clk);
    rst1 = 1'b0;
    @(negedge clk);
    cnt1 = 0;
    for (int f = 0; f < 18; f++) begin
      feat_valid1 = 1'b1;
      for (int k = 0; k < NF; k++) begin
        eb[k*4 +: 4] = 4'($urandom);
        checks++;
        if (feat_ready1 !== 1'b1) begin
          errors++;
          $display("FAIL s1_ready frame=%0d beat=%0d got=%b want=1", f, k, feat_ready1);
        end
        feat_data1 = eb[k*4 +: 4];
        feat_last1 = (k == NF - 1);
        @(negedge clk);
      end
      feat_valid1 = 1'b0; feat_last1 = 1'b0;
      checks++;
      if (res_valid1 !== 1'b0) begin
        errors++;
        $display("FAIL s1_early res_valid=%b want 0", res_valid1);
      end
      @(negedge clk);
      checks++;
      if (res_valid1 !== 1'b1 || clf_inp1 !== eb || res_class1 !== cls_of(eb)) begin
        errors++;
        $display("FAIL s1_result res_valid=%b clf_inp=%h class=%0d want 1 %h %0d",
                 res_valid1, clf_inp1, res_class1, eb, cls_of(eb));
      end
      res_ready1 = 1'b1;
      @(negedge clk);
      res_ready1 = 1'b0;
      cnt1 = (cnt1 + 1) % 16;
      checks++;
      if (frame_cnt1 !== 4'(cnt1)) begin
        errors++;
        $display("FAIL s1_frame_cnt got=%0d want=%0d", frame_cnt1, cnt1);
      end
    end
  endtask

  initial begin
    rst = 1'b1; feat_valid = 1'b0; feat_data = '0; feat_last = 1'b0; res_ready = 1'b0;
    rst1 = 1'b1; feat_valid1 = 1'b0; feat_data1 = '0; feat_last1 = 1'b0; res_ready1 = 1'b0;
    model_reset();
    @(negedge clk);
    test_reset();
    test_basic(0);
    test_basic(10);
    test_short_frame();
    test_long_frame();
    test_reset_mid();
    test_random();
    test_settle1_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1);
  end

endmodule
